sc_fifo: RTL and testbench
==========================

Name: sc_fifo

Overview:
- Single-clock synchronous FIFO with storage, occupancy count and threshold flags.
- Used as the buffering primitive behind latency-insensitive channel wrappers.
- Supports normal (registered-read) and show-ahead (first-word-fall-through) read modes.

Parameters:
- lpm_width, 8: data word width in bits.
- lpm_widthu, 3: usedw width; lpm_numwords must be ≤ 2**lpm_widthu.
- lpm_numwords, 8: depth in words, ≥2.
- lpm_showahead, "OFF": "OFF" = normal read; "ON" = show-ahead.
- almost_full_value, 1: almost_full threshold, 0..lpm_numwords.
- almost_empty_value, 1: almost_empty threshold, 0..lpm_numwords.
- overflow_checking, "ON": "ON" ignores wrreq while full.
- underflow_checking, "ON": "ON" ignores rdreq while empty.
- add_ram_output_register, "OFF": synthesis hint only; no change to port timing.
- use_eab / ram_block_type / enable_ecc / lpm_type: accepted and ignored. lpm_type is "scfifo".

Ports:
- clock  in  1  sole clock, rising edge.
- aclr  in  1  asynchronous active-high reset.
- sclr  in  1  synchronous active-high clear; tie 0 when unused.
- data  in  lpm_width  write data.
- wrreq  in  1  write request.
- rdreq  in  1  read request (normal) or read acknowledge (show-ahead).
- q  out  lpm_width  read data.
- empty  out  1  count == 0.
- full  out  1  count == lpm_numwords.
- almost_full  out  1  count ≥ almost_full_value.
- almost_empty  out  1  count < almost_empty_value.
- usedw  out  lpm_widthu  count modulo 2**lpm_widthu.
- eccstatus  out  2  constant 0.

Behaviour:
- State: wr_ptr, rd_ptr (wrap at lpm_numwords), internal count 0..lpm_numwords, q register in normal mode.
- aclr=1: clear immediately, regardless of clock. Pointers and count = 0, q = 0, empty = 1, full = 0, usedw = 0.
  - almost_empty = (almost_empty_value > 0).
  - almost_full = (almost_full_value == 0).
- sclr (sampled on edge): same clear as aclr. Priority: aclr > sclr > wrreq/rdreq.
- Effective write: we = wrreq & ~(full & overflow_checking=="ON").
- Effective read: re = rdreq & ~(empty & underflow_checking=="ON").
- Write: on an edge with we, mem[wr_ptr] <= data and wr_ptr advances.
- Read: on an edge with re, rd_ptr advances.
- Count: +1 on we-only, -1 on re-only, unchanged when both or neither.
- Full with wrreq&rdreq (checking ON): write ignored, read performed, count -1.
- Empty with wrreq&rdreq (checking ON): read ignored, write performed, count +1.
- Flags and usedw are combinational from the registered count, so they update the cycle after the request edge.
  - Write at edge t makes empty=0 from t+1.
  - usedw reads 0 when full and lpm_numwords == 2**lpm_widthu; full disambiguates.
- Normal mode:
  - On an edge with re, q <= mem[rd_ptr]; valid from the cycle after the edge, one-cycle latency.
  - q holds its value when there is no read, including after the FIFO drains.
- Show-ahead mode:
  - q = mem[rd_ptr] combinationally whenever empty=0.
  - rdreq pops; the next word appears the cycle after the edge.
  - A word written at edge t is visible on q at t+1.
  - q is don't-care while empty.
- Checking "OFF": pointers and count update unconditionally. Overflow/underflow corrupts contents; this is the user's responsibility and is not verified.
- No combinational path from inputs to any output except q in show-ahead mode, via rd_ptr memory read.

Decomposition:
- No shared package; all configuration is by parameter.
- One natural sub-module: sc_fifo_ram, a simple dual-port memory.
  - Synchronous write.
  - Read port selectable registered (normal) or asynchronous (show-ahead).
- Pointer/count/flag logic stays in sc_fifo.

Test Plan (width 8, widthu 3, numwords 8, almost_full_value 3, almost_empty_value 2):
- aclr pulse mid-cycle with 5 words stored → immediately empty=1, usedw=0, full=0, almost_empty=1, almost_full=0, q=0.
- Normal mode, write 0x11,0x22,0x33 on consecutive edges, then rdreq 3 cycles:
  - almost_full rises the cycle after the third write.
  - q = 0x11, 0x22, 0x33 one cycle after each read edge.
  - empty=1 after the third read; q holds 0x33.
- Fill 8 words → full=1, usedw=0. A 9th wrreq is ignored. Reading 8 words returns the original order.
- Show-ahead, write 0xA5 at edge t → q=0xA5 and empty=0 at t+1. rdreq at t+1 → empty=1 at t+2.
- Simultaneous wrreq&rdreq with count=4 → usedw stays 4 and data order is preserved.
  - Same with count=0 → usedw=1 and no underflow.
  - Same with count=8 → usedw=7 and the write is dropped.
- sclr asserted together with wrreq on a non-empty FIFO → next cycle empty=1, usedw=0; the write is discarded.

Source files
------------

// File: rtl/sc_fifo_ram.sv
// sc_fifo_ram: simple dual-port word store, registered or fall-through read port
module sc_fifo_ram #(
  parameter int width = 8,
  parameter int aw = 3,
  parameter int depth = 8,
  parameter bit show_ahead = 1'b0
) (
  input  logic             clock,
  input  logic             aclr,
  input  logic             sclr,
  input  logic             we,
  input  logic [aw-1:0]    wa,
  input  logic [width-1:0] wd,
  input  logic             re,
  input  logic [aw-1:0]    ra,
  output logic [width-1:0] q
);
  logic [width-1:0] mem [depth];
  logic [width-1:0] q_reg;
  always_ff @(posedge clock)
    if (we) mem[wa] <= wd;
  always_ff @(posedge clock or posedge aclr)
    if (aclr) q_reg <= '0;
    else if (sclr) q_reg <= '0;
    else if (re) q_reg <= mem[ra];
  // the registered path is pruned by synthesis in fall-through builds
  assign q = show_ahead ? mem[ra] : q_reg;
endmodule

// File: rtl/sc_fifo.sv
// sc_fifo: single-clock FIFO with occupancy count, threshold flags and optional show-ahead read
module sc_fifo #(
  parameter int    lpm_width = 8,
  parameter int    lpm_widthu = 3,
  parameter int    lpm_numwords = 8,
  parameter string lpm_showahead = "OFF",
  parameter int    almost_full_value = 1,
  parameter int    almost_empty_value = 1,
  parameter string overflow_checking = "ON",
  parameter string underflow_checking = "ON",
  parameter string add_ram_output_register = "OFF",
  parameter string use_eab = "ON",
  parameter string ram_block_type = "AUTO",
  parameter string enable_ecc = "FALSE",
  parameter string lpm_type = "scfifo"
) (
  input  logic                  clock,
  input  logic                  aclr,
  input  logic                  sclr,
  input  logic [lpm_width-1:0]  data,
  input  logic                  wrreq,
  input  logic                  rdreq,
  output logic [lpm_width-1:0]  q,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [lpm_widthu-1:0] usedw,
  output logic [1:0]            eccstatus
);
  localparam int aw = lpm_widthu;
  localparam int cw = lpm_widthu + 1;
  localparam logic [aw-1:0] last = aw'(lpm_numwords - 1);
  localparam bit ovf_chk = overflow_checking == "ON";
  localparam bit unf_chk = underflow_checking == "ON";
  localparam bit cfg_ok = lpm_numwords >= 2 && lpm_numwords <= 2 ** lpm_widthu &&
    almost_full_value <= lpm_numwords && almost_empty_value <= lpm_numwords &&
    lpm_type == "scfifo" && use_eab != "" && ram_block_type != "" &&
    enable_ecc != "" && add_ram_output_register != "";
  if (!cfg_ok) begin : g_bad_cfg
    $error("sc_fifo: invalid parameter set");
  end
  logic [aw-1:0] wr_ptr, rd_ptr;
  logic [cw-1:0] count;
  logic we, re;
  assign we = wrreq & ~(full & ovf_chk);
  assign re = rdreq & ~(empty & unf_chk);
  always_ff @(posedge clock or posedge aclr)
    if (aclr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (sclr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (we) wr_ptr <= wr_ptr == last ? '0 : wr_ptr + 1'b1;
      if (re) rd_ptr <= rd_ptr == last ? '0 : rd_ptr + 1'b1;
      if (we != re) count <= we ? count + 1'b1 : count - 1'b1;
    end
  assign empty = count == '0;
  assign full = count == cw'(lpm_numwords);
  assign almost_full = count >= cw'(almost_full_value);
  assign almost_empty = count < cw'(almost_empty_value);
  assign usedw = count[aw-1:0];
  assign eccstatus = '0;
  // a clear on the same edge discards any pending write or read
  sc_fifo_ram #(
    .width(lpm_width),
    .aw(aw),
    .depth(lpm_numwords),
    .show_ahead(lpm_showahead == "ON")
  ) u_ram (
    .clock(clock),
    .aclr(aclr),
    .sclr(sclr),
    .we(we & ~sclr),
    .wa(wr_ptr),
    .wd(data),
    .re(re & ~sclr),
    .ra(rd_ptr),
    .q(q)
  );
endmodule

// File: tb/tb_sc_fifo.sv
// tb_sc_fifo: directed checks of a normal-mode and a show-ahead sc_fifo driven in lockstep
module tb_sc_fifo;
  logic clock = 1'b0;
  logic aclr = 1'b1;
  logic sclr = 1'b0;
  logic [7:0] data = '0;
  logic wrreq = 1'b0;
  logic rdreq = 1'b0;
  logic [7:0] q_n, q_s;
  logic empty_n, full_n, af_n, ae_n, empty_s, full_s, af_s, ae_s;
  logic [2:0] usedw_n, usedw_s;
  logic [1:0] ecc_n, ecc_s;
  int passes = 0;
  int total = 0;

  always #5 clock = ~clock;

  sc_fifo #(.lpm_width(8), .lpm_widthu(3), .lpm_numwords(8), .lpm_showahead("OFF"),
            .almost_full_value(3), .almost_empty_value(2)) u_n (
    .clock(clock), .aclr(aclr), .sclr(sclr), .data(data), .wrreq(wrreq), .rdreq(rdreq),
    .q(q_n), .empty(empty_n), .full(full_n), .almost_full(af_n), .almost_empty(ae_n),
    .usedw(usedw_n), .eccstatus(ecc_n));

  sc_fifo #(.lpm_width(8), .lpm_widthu(3), .lpm_numwords(8), .lpm_showahead("ON"),
            .almost_full_value(3), .almost_empty_value(2)) u_s (
    .clock(clock), .aclr(aclr), .sclr(sclr), .data(data), .wrreq(wrreq), .rdreq(rdreq),
    .q(q_s), .empty(empty_s), .full(full_s), .almost_full(af_s), .almost_empty(ae_s),
    .usedw(usedw_s), .eccstatus(ecc_s));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    tick();
    tick();
    aclr = 1'b0;
    chk("rst_empty", empty_n, 1);
    chk("rst_full", full_n, 0);
    chk("rst_usedw", usedw_n, 0);
    chk("rst_ae", ae_n, 1);
    chk("rst_af", af_n, 0);
    chk("rst_q", q_n, 8'h00);
    chk("rst_ecc", ecc_n, 0);
    wrreq = 1'b1;
    data = 8'h11;
    tick();
    chk("w1_empty", empty_n, 0);
    chk("w1_ae", ae_n, 1);
    data = 8'h22;
    tick();
    chk("w2_af", af_n, 0);
    chk("w2_ae", ae_n, 0);
    data = 8'h33;
    tick();
    chk("w3_af", af_n, 1);
    chk("w3_usedw", usedw_n, 3);
    chk("sa_head", q_s, 8'h11);
    wrreq = 1'b0;
    rdreq = 1'b1;
    tick();
    chk("r1_q", q_n, 8'h11);
    chk("r1_usedw", usedw_n, 2);
    chk("sa_next", q_s, 8'h22);
    tick();
    chk("r2_q", q_n, 8'h22);
    tick();
    chk("r3_q", q_n, 8'h33);
    chk("r3_empty", empty_n, 1);
    rdreq = 1'b0;
    tick();
    chk("hold_q", q_n, 8'h33);
    wrreq = 1'b1;
    for (int i = 0; i < 8; i++) begin
      data = 8'h80 + 8'(i);
      tick();
    end
    chk("fill_full", full_n, 1);
    chk("fill_usedw", usedw_n, 0);
    data = 8'hFF;
    tick();
    chk("ovf_full", full_n, 1);
    chk("ovf_usedw", usedw_n, 0);
    chk("sa_fill_head", q_s, 8'h80);
    wrreq = 1'b0;
    rdreq = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("drain%0d", i), q_n, 8'h80 + 8'(i));
    end
    rdreq = 1'b0;
    chk("drain_empty", empty_n, 1);
    wrreq = 1'b1;
    data = 8'hA5;
    tick();
    wrreq = 1'b0;
    chk("sa_q", q_s, 8'hA5);
    chk("sa_empty0", empty_s, 0);
    rdreq = 1'b1;
    tick();
    rdreq = 1'b0;
    chk("sa_empty1", empty_s, 1);
    chk("n_a5", q_n, 8'hA5);
    wrreq = 1'b1;
    rdreq = 1'b1;
    data = 8'h01;
    tick();
    chk("wr0_usedw", usedw_n, 1);
    chk("wr0_q", q_n, 8'hA5);
    rdreq = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      data = 8'(i);
      tick();
    end
    rdreq = 1'b1;
    data = 8'h05;
    tick();
    chk("wr4a_usedw", usedw_n, 4);
    chk("wr4a_q", q_n, 8'h01);
    data = 8'h06;
    tick();
    chk("wr4b_usedw", usedw_n, 4);
    chk("wr4b_q", q_n, 8'h02);
    rdreq = 1'b0;
    for (int i = 7; i <= 10; i++) begin
      data = 8'(i);
      tick();
    end
    chk("wr8_full", full_n, 1);
    rdreq = 1'b1;
    data = 8'hEE;
    tick();
    chk("wr8_usedw", usedw_n, 7);
    chk("wr8_full0", full_n, 0);
    chk("wr8_q", q_n, 8'h03);
    wrreq = 1'b0;
    for (int i = 4; i <= 10; i++) begin
      tick();
      chk($sformatf("order%0d", i), q_n, 8'(i));
    end
    rdreq = 1'b0;
    chk("order_empty", empty_n, 1);
    wrreq = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data = 8'hD0 + 8'(i);
      tick();
    end
    rdreq = 1'b1;
    wrreq = 1'b0;
    tick();
    chk("pre_sclr_q", q_n, 8'hD0);
    rdreq = 1'b0;
    sclr = 1'b1;
    wrreq = 1'b1;
    data = 8'h77;
    tick();
    sclr = 1'b0;
    wrreq = 1'b0;
    chk("sclr_empty", empty_n, 1);
    chk("sclr_usedw", usedw_n, 0);
    chk("sclr_q", q_n, 8'h00);
    wrreq = 1'b1;
    for (int i = 0; i < 6; i++) begin
      data = 8'hC0 + 8'(i);
      tick();
    end
    wrreq = 1'b0;
    rdreq = 1'b1;
    tick();
    rdreq = 1'b0;
    chk("pre_aclr_usedw", usedw_n, 5);
    chk("pre_aclr_q", q_n, 8'hC0);
    #3;
    aclr = 1'b1;
    #1;
    chk("aclr_empty", empty_n, 1);
    chk("aclr_usedw", usedw_n, 0);
    chk("aclr_full", full_n, 0);
    chk("aclr_ae", ae_n, 1);
    chk("aclr_af", af_n, 0);
    chk("aclr_q", q_n, 8'h00);
    #2;
    aclr = 1'b0;
    tick();
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
